// File: rtl/dn_loader_pkg.sv
// Shared types and constants for the HPS download sequencer.
// Download indices, variant codes, controller states and the variant decoder.
package dn_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SETTLE,
        RUN
    } dn_state_e;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    localparam logic [7:0] MOD_SBAG = 8'd1;
    localparam logic [7:0] MOD_PICK = 8'd2;
    localparam logic [7:0] MOD_SQUA = 8'd3;

    typedef struct packed {
        logic sbag;
        logic pick;
        logic squa;
    } dn_mod_t;

    function automatic dn_mod_t decode_mod(input logic [7:0] v);
        dn_mod_t m;
        m = '0;
        case (v)
            MOD_SBAG: m.sbag = 1'b1;
            MOD_PICK: m.pick = 1'b1;
            MOD_SQUA: m.squa = 1'b1;
            default:  m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dn_dip_bank.sv
// 8x8 DIP switch register file: one write port, byte 0 exposed to the core.
// Synchronous active-high reset clears every byte.
module dn_dip_bank (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       we_i,
    input  logic [2:0] waddr_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] byte0_o
);

    logic [7:0] mem_q [8];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign byte0_o = mem_q[0];

endmodule

// File: rtl/dn_loader_ctrl.sv
// HPS download sequencer: routes ROM bytes to the core, latches variant and DIP bytes,
// and owns core reset. Optional ROM checksum ports enabled by DN_LOADER_CHECKSUM_EN.
module dn_loader_ctrl
    import dn_loader_pkg::*;
#(
    parameter int unsigned ROM_BYTES     = 81920,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned DN_AW         = 17
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             ext_reset,
    input  logic             ioctl_download,
    input  logic             ioctl_wr,
    input  logic [24:0]      ioctl_addr,
    input  logic [7:0]       ioctl_dout,
    input  logic [7:0]       ioctl_index,
    output logic [DN_AW-1:0] dn_addr,
    output logic [7:0]       dn_data,
    output logic             dn_wr,
    output logic             core_reset,
    output logic             mod_sbag,
    output logic             mod_pick,
    output logic             mod_squa,
    output logic [7:0]       dipsw,
    output logic             rom_short,
    output logic             rom_over,
`ifdef DN_LOADER_CHECKSUM_EN
    input  logic [7:0]       exp_sum,
    output logic [7:0]       rom_sum,
    output logic             sum_bad,
`endif
    output logic             busy
);

    localparam int unsigned SW          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [17:0]   ROM_CNT     = 18'(ROM_BYTES);
    localparam logic [24:0]   ROM_LIM     = 25'(ROM_BYTES);

    dn_state_e         state_q, state_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [17:0]       cnt_q, cnt_d;
    logic              short_q, short_d;
    logic              over_q, over_d;
    dn_mod_t           mod_q, mod_d;
    logic [7:0]        pend_q, pend_d;
    logic              core_reset_q, core_reset_d;
    logic              dn_wr_q, dn_wr_d;
    logic [DN_AW-1:0]  dn_addr_q, dn_addr_d;
    logic [7:0]        dn_data_q, dn_data_d;
`ifdef DN_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              sum_bad_q, sum_bad_d;
`endif

    logic rom_wr, in_range, acc, over_wr, load_req, enter_load, dip_we;

    assign rom_wr     = ioctl_wr && (ioctl_index == IDX_ROM);
    assign in_range   = ioctl_addr < ROM_LIM;
    assign acc        = rom_wr && in_range;
    assign over_wr    = rom_wr && !in_range;
    assign load_req   = ioctl_download && (ioctl_index == IDX_ROM);
    assign enter_load = load_req && (state_q != LOAD);
    assign dip_we     = ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr[24:3] == 22'd0);

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        cnt_d        = cnt_q;
        short_d      = short_q;
        over_d       = over_q;
        mod_d        = mod_q;
        pend_d       = pend_q;
        dn_wr_d      = acc;
        dn_addr_d    = dn_addr_q;
        dn_data_d    = dn_data_q;
        core_reset_d = (state_q == RUN) ? ext_reset : 1'b1;
`ifdef DN_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
        sum_bad_d    = sum_bad_q;
`endif

        if (acc) begin
            dn_addr_d = ioctl_addr[DN_AW-1:0];
            dn_data_d = ioctl_dout;
        end

        if (ioctl_wr && (ioctl_index == IDX_MOD)) begin
            pend_d = ioctl_dout;
        end

        // A write in the entry cycle already counts toward the new load.
        if (enter_load) begin
            cnt_d   = acc ? 18'd1 : 18'd0;
            short_d = 1'b0;
            over_d  = over_wr;
`ifdef DN_LOADER_CHECKSUM_EN
            sum_d   = acc ? ioctl_dout : 8'h00;
`endif
        end else begin
            if (acc && (cnt_q != '1)) begin
                cnt_d = cnt_q + 18'd1;
            end
            if (over_wr) begin
                over_d = 1'b1;
            end
`ifdef DN_LOADER_CHECKSUM_EN
            if (acc && (state_q == LOAD)) begin
                sum_d = sum_q + ioctl_dout;
            end
`endif
        end

        if (load_req) begin
            state_d = LOAD;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = RUN;
                    mod_d   = decode_mod(pend_q);
                end
                LOAD: begin
                    if (!ioctl_download) begin
                        state_d  = SETTLE;
                        settle_d = '0;
                        short_d  = cnt_d < ROM_CNT;
                        mod_d    = decode_mod(pend_q);
`ifdef DN_LOADER_CHECKSUM_EN
                        sum_bad_d = (sum_d != exp_sum);
`endif
                    end
                end
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = RUN;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= IDLE;
            settle_q     <= '0;
            cnt_q        <= '0;
            short_q      <= 1'b0;
            over_q       <= 1'b0;
            mod_q        <= '0;
            pend_q       <= 8'h00;
            core_reset_q <= 1'b1;
            dn_wr_q      <= 1'b0;
            dn_addr_q    <= '0;
            dn_data_q    <= 8'h00;
`ifdef DN_LOADER_CHECKSUM_EN
            sum_q        <= 8'h00;
            sum_bad_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            cnt_q        <= cnt_d;
            short_q      <= short_d;
            over_q       <= over_d;
            mod_q        <= mod_d;
            pend_q       <= pend_d;
            core_reset_q <= core_reset_d;
            dn_wr_q      <= dn_wr_d;
            dn_addr_q    <= dn_addr_d;
            dn_data_q    <= dn_data_d;
`ifdef DN_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
            sum_bad_q    <= sum_bad_d;
`endif
        end
    end

    dn_dip_bank u_dip_bank (
        .clk_i   (clk_sys),
        .rst_i   (reset),
        .we_i    (dip_we),
        .waddr_i (ioctl_addr[2:0]),
        .wdata_i (ioctl_dout),
        .byte0_o (dipsw)
    );

    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign dn_wr      = dn_wr_q;
    assign core_reset = core_reset_q;
    assign mod_sbag   = mod_q.sbag;
    assign mod_pick   = mod_q.pick;
    assign mod_squa   = mod_q.squa;
    assign rom_short  = short_q;
    assign rom_over   = over_q;
    assign busy       = (state_q == LOAD) || (state_q == SETTLE);
`ifdef DN_LOADER_CHECKSUM_EN
    assign rom_sum    = sum_q;
    assign sum_bad    = sum_bad_q;
`endif

endmodule

// File: tb/tb_dn_loader_ctrl.sv
// Bench for dn_loader_ctrl: scoreboard on the ROM write port, vector table for RUN-time
// writes, hand sequences for load/settle/reset corners.
module tb_dn_loader_ctrl;

    localparam int unsigned RB = 512;
    localparam int unsigned SC = 16;

    logic        clk = 1'b0;
    logic        reset, ext_reset, ioctl_download, ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout, ioctl_index;
    logic [16:0] dn_addr;
    logic [7:0]  dn_data, dipsw;
    logic        dn_wr, core_reset, mod_sbag, mod_pick, mod_squa, rom_short, rom_over, busy;
`ifdef DN_LOADER_CHECKSUM_EN
    logic [7:0]  exp_sum, rom_sum;
    logic        sum_bad;
`endif

    always #5 clk = ~clk;

    dn_loader_ctrl #(
        .ROM_BYTES     (RB),
        .SETTLE_CYCLES (SC),
        .DN_AW         (17)
    ) dut (
        .clk_sys        (clk),
        .reset          (reset),
        .ext_reset      (ext_reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .core_reset     (core_reset),
        .mod_sbag       (mod_sbag),
        .mod_pick       (mod_pick),
        .mod_squa       (mod_squa),
        .dipsw          (dipsw),
        .rom_short      (rom_short),
        .rom_over       (rom_over),
`ifdef DN_LOADER_CHECKSUM_EN
        .exp_sum        (exp_sum),
        .rom_sum        (rom_sum),
        .sum_bad        (sum_bad),
`endif
        .busy           (busy)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        int unsigned at;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    // Every dn_wr must match the oldest outstanding in-range ROM write, one cycle later.
    always @(negedge clk) begin
        if (dn_wr === 1'b1) begin
            if (sb.size() == 0) begin
                chk("dn_wr_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("dn_addr", 32'(dn_addr), 32'(e.addr[16:0]));
                chk("dn_data", 32'(dn_data), 32'(e.data));
                chk("dn_latency", cyc, e.at);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        exp_t x;
        ioctl_wr    = 1'b1;
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        if (idx == 8'd0 && a < 25'(RB)) begin
            x.addr = a;
            x.data = d;
            x.at   = cyc + 1;
            sb.push_back(x);
        end
        @(negedge clk);
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_settle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk(name, n, SC);
    endtask

    typedef struct {
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  dout;
        logic        exp_wr;
        logic [7:0]  exp_dip;
    } vec_t;

    vec_t vt[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{8'd0,   25'd5,   8'h11, 1'b1, 8'h00};
        vt[1] = '{8'd0,   25'd511, 8'h22, 1'b1, 8'h00};
        vt[2] = '{8'd0,   25'd512, 8'h33, 1'b0, 8'h00};
        vt[3] = '{8'd254, 25'd0,   8'hA5, 1'b0, 8'hA5};
        vt[4] = '{8'd254, 25'd8,   8'h5A, 1'b0, 8'hA5};
        vt[5] = '{8'd254, 25'd3,   8'h77, 1'b0, 8'hA5};
        vt[6] = '{8'd7,   25'd0,   8'h99, 1'b0, 8'hA5};
        vt[7] = '{8'd1,   25'd0,   8'h02, 1'b0, 8'hA5};
        vt[8] = '{8'd254, 25'd0,   8'h3C, 1'b0, 8'h3C};
        vt[9] = '{8'd0,   25'd0,   8'hC3, 1'b1, 8'h3C};

        reset = 1'b1; ext_reset = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0;
`ifdef DN_LOADER_CHECKSUM_EN
        exp_sum = 8'h10;
`endif
        repeat (3) tick();
        chk("rst_core_reset", 32'(core_reset), 1);
        chk("rst_dn_wr", 32'(dn_wr), 0);
        chk("rst_dn_addr", 32'(dn_addr), 0);
        chk("rst_dn_data", 32'(dn_data), 0);
        chk("rst_mods", {29'd0, mod_sbag, mod_pick, mod_squa}, 0);
        chk("rst_dipsw", 32'(dipsw), 0);
        chk("rst_flags", {30'd0, rom_short, rom_over}, 0);
        chk("rst_busy", 32'(busy), 0);

        reset = 1'b0;
        tick();
        chk("idle_core_reset", 32'(core_reset), 1);
        tick();
        chk("run_core_reset", 32'(core_reset), 0);
        chk("run_mods", {29'd0, mod_sbag, mod_pick, mod_squa}, 0);

        // Variant 3 pending, then a full-length load.
        wr_byte(8'd1, 25'd0, 8'd3);
        chk("pend_no_squa", 32'(mod_squa), 0);
        ioctl_download = 1'b1; ioctl_index = 8'd0;
        tick();
        chk("load_busy", 32'(busy), 1);
        for (int a = 0; a < RB - 1; a++) begin
            wr_byte(8'd0, 25'(a), 8'(a));
            if (a == RB / 2) begin
                chk("load_core_reset", 32'(core_reset), 1);
                chk("load_no_squa", 32'(mod_squa), 0);
            end
        end
        // Final strobe coincides with download falling.
        ioctl_download = 1'b0;
        wr_byte(8'd0, 25'(RB - 1), 8'(RB - 1));
        chk("settle_busy", 32'(busy), 1);
        chk("settle_squa", 32'(mod_squa), 1);
        chk("settle_pick", 32'(mod_pick), 0);
        chk("full_rom_short", 32'(rom_short), 0);
        chk("full_rom_over", 32'(rom_over), 0);
        chk("settle_core_reset", 32'(core_reset), 1);
        wait_settle("settle_len");
        chk("post_settle_core_reset", 32'(core_reset), 1);
        tick();
        chk("run_core_reset2", 32'(core_reset), 0);
        chk("sb_drain_full", sb.size(), 0);

        for (int i = 0; i < 10; i++) begin
            wr_byte(vt[i].idx, vt[i].addr, vt[i].dout);
            chk($sformatf("vec%0d_dn_wr", i), 32'(dn_wr), 32'(vt[i].exp_wr));
            chk($sformatf("vec%0d_dipsw", i), 32'(dipsw), 32'(vt[i].exp_dip));
            chk($sformatf("vec%0d_core_reset", i), 32'(core_reset), 0);
        end
        chk("run_over_set", 32'(rom_over), 1);
        chk("run_squa_held", 32'(mod_squa), 1);
        chk("run_pick_held", 32'(mod_pick), 0);

        ext_reset = 1'b1;
        tick();
        chk("ext_reset_on", 32'(core_reset), 1);
        ext_reset = 1'b0;
        tick();
        chk("ext_reset_off", 32'(core_reset), 0);

        // Short load with one out-of-range byte.
        ioctl_download = 1'b1; ioctl_index = 8'd0;
        tick();
        chk("load_clr_over", 32'(rom_over), 0);
        for (int a = 0; a < 100; a++) wr_byte(8'd0, 25'(a), 8'(a + 3));
        wr_byte(8'd0, 25'(RB), 8'hEE);
        ioctl_download = 1'b0;
        tick();
        chk("short_over", 32'(rom_over), 1);
        chk("short_short", 32'(rom_short), 1);
        chk("short_pick", 32'(mod_pick), 1);
        chk("short_squa", 32'(mod_squa), 0);
        wait_settle("settle_len2");
        tick();

        // Reset in the middle of a load.
        ioctl_download = 1'b1; ioctl_index = 8'd0;
        tick();
        wr_byte(8'd0, 25'd7, 8'h44);
        wr_byte(8'd0, 25'd8, 8'h45);
        reset = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 25'd9; ioctl_dout = 8'h46;
        tick();
        chk("abort_dn_wr", 32'(dn_wr), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_core_reset", 32'(core_reset), 1);
        chk("abort_mods", {29'd0, mod_sbag, mod_pick, mod_squa}, 0);
        chk("abort_dipsw", 32'(dipsw), 0);
        ioctl_wr = 1'b0; ioctl_download = 1'b0; reset = 1'b0;
        tick();
        chk("abort_idle_busy", 32'(busy), 0);
        chk("abort_idle_core_reset", 32'(core_reset), 1);
        tick();
        chk("abort_run_core_reset", 32'(core_reset), 0);

        // Restart during SETTLE: counter must start over.
        ioctl_download = 1'b1; ioctl_index = 8'd0;
        tick();
        for (int a = 0; a < 10; a++) wr_byte(8'd0, 25'(a), 8'(a));
        ioctl_download = 1'b0;
        tick();
        chk("restart_settle", 32'(busy), 1);
        tick();
        tick();
        ioctl_download = 1'b1;
        tick();
        repeat (SC + 4) tick();
        chk("restart_held_load", 32'(busy), 1);
        for (int a = 0; a < RB - 6; a++) wr_byte(8'd0, 25'(a), 8'(a ^ 8'h5A));
        ioctl_download = 1'b0;
        wr_byte(8'd0, 25'(RB - 6), 8'h01);
        chk("restart_short", 32'(rom_short), 1);
        wait_settle("settle_len3");
        tick();

`ifdef DN_LOADER_CHECKSUM_EN
        ioctl_download = 1'b1; ioctl_index = 8'd0;
        tick();
        wr_byte(8'd0, 25'd0, 8'h80);
        ioctl_download = 1'b0;
        wr_byte(8'd0, 25'd1, 8'h90);
        chk("rom_sum", 32'(rom_sum), 32'h10);
        chk("sum_bad", 32'(sum_bad), 0);
        wait_settle("settle_len4");
        wr_byte(8'd0, 25'd2, 8'h55);
        chk("rom_sum_frozen", 32'(rom_sum), 32'h10);
`endif

        tick();
        chk("sb_drain_end", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dn_loader_ctrl.md
Name: dn_loader_ctrl

Overview:
Sequences the HPS download stream into the arcade core and owns the core's reset.
- Routes index-0 bytes into the core ROM/RAM write port.
- Latches the game-variant byte (index 1) and the DIP bank (index 254).
- Holds the core in reset during a ROM load and for a settle window after it.
- Sits between hps_io and the bagman core in the top-level emu wrapper.

Parameters:
ROM_BYTES, 81920, number of index-0 bytes the core expects; writes at or above this are dropped.
SETTLE_CYCLES, 16, clk_sys cycles that core_reset stays high after download ends (min 1).
DN_AW, 17, width of dn_addr.

Ports:
clk_sys  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous active-high reset.
ext_reset  in  1  OSD/button reset request, level.
ioctl_download  in  1  download in progress.
ioctl_wr  in  1  one-cycle byte strobe.
ioctl_addr  in  25  byte address within current index.
ioctl_dout  in  8  byte data.
ioctl_index  in  8  download index.
dn_addr  out  DN_AW  core write address.
dn_data  out  8  core write data.
dn_wr  out  1  core write strobe.
core_reset  out  1  reset to core.
mod_sbag  out  1  variant 1 selected.
mod_pick  out  1  variant 2 selected.
mod_squa  out  1  variant 3 selected.
dipsw  out  8  DIP byte 0.
rom_short  out  1  last ROM load delivered fewer than ROM_BYTES bytes.
rom_over  out  1  last ROM load had writes at addr >= ROM_BYTES.
busy  out  1  state is LOAD or SETTLE.

Behaviour:
- Reset values: state IDLE; core_reset=1; dn_wr=0; dn_addr=0; dn_data=0; mod_*=0; dipsw=0 (all 8 DIP bytes 0); rom_short=0; rom_over=0; busy=0; byte counter=0; settle counter=0.
- States:
  - IDLE: after reset, waits one cycle, then goes to RUN.
  - LOAD: entered when ioctl_download=1 and ioctl_index=0, from any state. Clears byte counter, rom_short and rom_over.
  - SETTLE: entered when ioctl_download falls in LOAD. Counts SETTLE_CYCLES, then goes to RUN.
  - RUN: normal operation.
- Download restarted during SETTLE → back to LOAD, counters cleared.
- core_reset is registered: 1 in IDLE, LOAD and SETTLE; in RUN it equals the previous cycle's ext_reset.
- ROM write path, 1-cycle latency:
  - ioctl_wr with index 0 and ioctl_addr < ROM_BYTES → next cycle dn_wr=1, dn_addr=ioctl_addr[DN_AW-1:0], dn_data=ioctl_dout.
  - dn_addr and dn_data hold their value when dn_wr=0.
- Byte counter (18 bits, saturating) increments on each accepted index-0 write.
- Any index-0 write at or above ROM_BYTES sets rom_over; no dn_wr is issued.
- On the LOAD→SETTLE transition, rom_short = (counter < ROM_BYTES).
- A write strobe in the same cycle ioctl_download falls is still processed; counter and rom_short include it.
- Variant byte: any ioctl_wr with index 1 latches ioctl_dout into a pending register. mod_* are decoded from it only on entry to SETTLE, or on the IDLE→RUN step, so the variant never changes while the core runs.
- Variant decode: one-hot. Value 1→sbag, 2→pick, 3→squa; any other value → all zero.
- DIP bank: ioctl_wr with index 254 and ioctl_addr[24:3]==0 writes byte ioctl_addr[2:0]. Accepted in any state and applied immediately; dipsw mirrors byte 0 on the next cycle.
- Writes with any other index are ignored.
- reset mid-LOAD aborts the load: all outputs return to reset values and the state goes to IDLE.

Optional Feature:
Macro: DN_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output rom_sum[7:0]: modulo-256 sum of accepted index-0 bytes, cleared on LOAD entry and frozen in SETTLE/RUN.
  - Adds input exp_sum[7:0] and output sum_bad: on SETTLE entry, sum_bad = (rom_sum != exp_sum).
  - Reset value of both outputs is 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package dn_loader_pkg:
  - state enum {IDLE, LOAD, SETTLE, RUN};
  - index constants IDX_ROM=0, IDX_MOD=1, IDX_DIP=254;
  - variant codes MOD_SBAG=1, MOD_PICK=2, MOD_SQUA=3.
- One sub-module, dn_dip_bank: 8x8 register file with write port and byte-0 read.
- The FSM, write path and counters stay in dn_loader_ctrl.

Test Plan:
- Reset released, no download → core_reset=1 for 2 cycles then 0; mod_*=0; dipsw=0.
- Index 0 load of ROM_BYTES bytes (data=addr[7:0]) → each dn_wr exactly 1 cycle after ioctl_wr with matching addr/data; core_reset stays 1 for SETTLE_CYCLES after download falls; rom_short=0, rom_over=0.
- Load 100 bytes, then addr 81920 → no dn_wr for the out-of-range byte; rom_over=1; rom_short=1.
- Index 1 byte 3, then index 0 load → mod_squa rises only on SETTLE entry. A later index 1 byte 2 during RUN leaves mod_squa=1 until the next load.
- Index 254 writes 0xA5 at addr 0 and 0x5A at addr 8 during RUN → dipsw=0xA5 one cycle later; the addr-8 write is ignored; core_reset unaffected.
- reset asserted mid-LOAD → dn_wr=0 and state IDLE next cycle; download re-asserted during SETTLE → returns to LOAD, counter restarts; with DN_LOADER_CHECKSUM_EN, bytes 0x80,0x90 → rom_sum=0x10.
